// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I load/store func3 encodings and the LSU state type
package riscv_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store side maps func3/addr/wdata to be/shifted wdata/misaligned; load side extends rdata by latched func3/addr
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic        misaligned,
    input  logic [2:0]  ld_func3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ld_result
);
    logic [31:0] sh;
    always_comb begin
        be = func3[1:0] == 2'b00 ? 4'b0001 << addr_lo : func3[1:0] == 2'b01 ? 4'b0011 << addr_lo : 4'b1111;
        wdata_sh = func3[1:0] == 2'b00 ? {4{wdata[7:0]}} : func3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        misaligned = func3[1:0] == 2'b11 || (func3[2] && (we || func3[1]))
                     || (func3[1:0] == 2'b01 && addr_lo[0]) || (func3[1:0] == 2'b10 && addr_lo != 2'b00);
        sh = rdata >> {ld_addr_lo, 3'b000};
        ld_result = ld_func3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                    ld_func3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                    ld_func3 == F3_BU ? {24'b0, sh[7:0]} :
                    ld_func3 == F3_HU ? {16'b0, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage LSU; EX/MEM request in, req/ack data bus out, load_data/stall/misalign_exc/bus_timeout to pipeline
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  func3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misalign_exc,
    output logic        bus_timeout
);
    lsu_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [31:0] addr_q, wdata_q, wdata_sh, ld_result;
    logic [2:0] f3_q;
    logic [3:0] be_q, be;
    logic we_q, acc, bad;
    assign acc = mem_read_in | mem_write_in;
    lsu_align u_align (
        .func3(func3_in),
        .addr_lo(addr_in[1:0]),
        .we(mem_write_in),
        .wdata(wdata_in),
        .be(be),
        .wdata_sh(wdata_sh),
        .misaligned(bad),
        .ld_func3(f3_q),
        .ld_addr_lo(addr_q[1:0]),
        .rdata(bus_rdata),
        .ld_result(ld_result)
    );
    // The cycle carrying the timeout pulse lets the pipeline advance past the aborted access, so it is not restarted.
    always_comb begin
        bus_req = state == REQ;
        bus_we = bus_req & we_q;
        bus_addr = bus_req ? {addr_q[31:2], 2'b00} : '0;
        bus_be = bus_req ? be_q : '0;
        bus_wdata = bus_req ? wdata_q : '0;
        stall = bus_req || (state == IDLE && acc && !bad && !bus_timeout);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            f3_q <= '0;
            be_q <= '0;
            we_q <= 1'b0;
            load_data <= '0;
            misalign_exc <= 1'b0;
            bus_timeout <= 1'b0;
        end else begin
            misalign_exc <= 1'b0;
            bus_timeout <= 1'b0;
            case (state)
                IDLE: if (acc && !bus_timeout) begin
                    if (bad) misalign_exc <= 1'b1;
                    else begin
                        addr_q <= addr_in;
                        f3_q <= func3_in;
                        we_q <= mem_write_in;
                        be_q <= be;
                        wdata_q <= wdata_sh;
                        cnt <= '0;
                        state <= REQ;
                    end
                end
                REQ: if (bus_ack) begin
                    if (!we_q) load_data <= ld_result;
                    cnt <= '0;
                    state <= DONE;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    bus_timeout <= 1'b1;
                    cnt <= '0;
                    state <= IDLE;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench with a load-result scoreboard
module tb_mem_stage_lsu;
    logic clk = 1'b0, rst = 1'b1;
    logic mem_read_in = 1'b0, mem_write_in = 1'b0, bus_ack = 1'b0;
    logic [2:0] func3_in = '0;
    logic [31:0] addr_in = '0, wdata_in = '0, bus_rdata = '0;
    logic bus_req, bus_we, stall, misalign_exc, bus_timeout;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0] bus_be;
    int tests = 0, fails = 0;
    logic [31:0] sb[$];
    logic [31:0] last_ld = '0, exp_ld;
    always #5 clk = ~clk;
    mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .func3_in(func3_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .load_data(load_data), .stall(stall),
        .misalign_exc(misalign_exc), .bus_timeout(bus_timeout)
    );
    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        tests++;
        if (o !== e) begin
            fails++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
    endtask
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int wait_n, input logic [31:0] rw,
                       input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] eld);
        int st;
        st = 0;
        @(posedge clk); #1;
        mem_read_in = rd; mem_write_in = wr; func3_in = f3; addr_in = a; wdata_in = wd;
        if (rd && !wr) sb.push_back(eld);
        @(negedge clk);
        if (stall) st++;
        chk("idle_no_req", bus_req, 1'b0);
        for (int i = 0; i <= wait_n; i++) begin
            @(posedge clk); #1;
            if (i == wait_n) begin bus_ack = 1'b1; bus_rdata = rw; end
            @(negedge clk);
            if (stall) st++;
            chk("req", bus_req, 1'b1);
            chk("addr", bus_addr, ea);
            chk("be", bus_be, ebe);
            chk("we", bus_we, wr);
            if (wr) chk("wdata", bus_wdata, ewd);
        end
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        if (stall) st++;
        chk("done_req", bus_req, 1'b0);
        chk("stall_cycles", st, wait_n + 2);
        chk("no_timeout", bus_timeout, 1'b0);
        if (rd && !wr) begin
            exp_ld = sb.pop_front();
            chk("load_data", load_data, exp_ld);
            last_ld = exp_ld;
        end else chk("load_hold", load_data, last_ld);
        @(posedge clk); #1;
        mem_read_in = 1'b0; mem_write_in = 1'b0;
    endtask
    task automatic bad_acc(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        mem_read_in = rd; mem_write_in = wr; func3_in = f3; addr_in = a;
        @(negedge clk);
        chk("mis_stall", stall, 1'b0);
        chk("mis_req0", bus_req, 1'b0);
        @(posedge clk); #1;
        mem_read_in = 1'b0; mem_write_in = 1'b0;
        @(negedge clk);
        chk("mis_pulse", misalign_exc, 1'b1);
        chk("mis_req1", bus_req, 1'b0);
        @(negedge clk);
        chk("mis_clear", misalign_exc, 1'b0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_exc", {misalign_exc, bus_timeout}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        run(1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 0, 32'hDEADBEEF);
        run(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF0000, 32'h100, 4'b1000, 0, 32'hFFFFFF80);
        run(1, 0, 3'b100, 32'h103, 0, 1, 32'h80FF0000, 32'h100, 4'b1000, 0, 32'h00000080);
        run(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 0, 32'h200, 4'b1100, 32'hABCDABCD, 0);
        run(0, 1, 3'b000, 32'h001, 32'h0000005A, 2, 0, 32'h000, 4'b0010, 32'h5A5A5A5A, 0);
        run(1, 1, 3'b010, 32'h30C, 32'hCAFEF00D, 0, 0, 32'h30C, 4'b1111, 32'hCAFEF00D, 0);
        run(1, 0, 3'b001, 32'h102, 0, 0, 32'h8001_0000, 32'h100, 4'b1100, 0, 32'hFFFF8001);
        run(1, 0, 3'b101, 32'h102, 0, 3, 32'h8001_0000, 32'h100, 4'b1100, 0, 32'h00008001);
        bad_acc(1, 0, 3'b010, 32'h101);
        bad_acc(0, 1, 3'b001, 32'h203);
        bad_acc(0, 1, 3'b100, 32'h000);
        @(posedge clk); #1;
        mem_read_in = 1'b1; func3_in = 3'b010; addr_in = 32'h10;
        @(negedge clk);
        chk("to_stall", stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_req", bus_req, 1'b1);
        end
        @(negedge clk);
        chk("to_drop", bus_req, 1'b0);
        chk("to_pulse", bus_timeout, 1'b1);
        chk("to_nostall", stall, 1'b0);
        chk("to_load", load_data, last_ld);
        @(posedge clk); #1;
        mem_read_in = 1'b0;
        @(negedge clk);
        chk("to_clear", bus_timeout, 1'b0);
        chk("to_idle", bus_req, 1'b0);
        @(posedge clk); #1;
        mem_read_in = 1'b1; func3_in = 3'b010; addr_in = 32'h20;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_req", bus_req, 1'b1);
        #2;
        rst = 1'b1; mem_read_in = 1'b0;
        #1;
        chk("rst_async_req", bus_req, 1'b0);
        chk("rst_async_stall", stall, 1'b0);
        chk("rst_async_load", load_data, 32'h0);
        last_ld = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", bus_req, 1'b0);
        end
        run(1, 0, 3'b000, 32'h041, 0, 0, 32'h0000_7F00, 32'h040, 4'b0010, 0, 32'h0000007F);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit that consumes the EX/MEM pipeline outputs: access request, func3, ALU address and store data. It runs a req/ack transaction on the data bus, generates byte enables and lane-shifted store data, and sign- or zero-extends load data for writeback. It holds the pipeline with a stall while a bus transaction is outstanding, and flags misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait in REQ for bus_ack before aborting with bus_timeout (1..65535)
CNT_W, 16, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mem_read_in  in  1  load request from EX/MEM
mem_write_in  in  1  store request from EX/MEM
func3_in  in  3  access size/sign (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW)
addr_in  in  32  byte address (EX/MEM alu_result)
wdata_in  in  32  store data, right-aligned
bus_req  out  1  transaction request
bus_we  out  1  1 = write
bus_addr  out  32  word address, {addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-shifted store data
bus_ack  in  1  single-cycle completion from memory
bus_rdata  in  32  read word, valid with bus_ack
load_data  out  32  extended load result to MEM/WB
stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
misalign_exc  out  1  one-cycle pulse: misaligned or illegal func3
bus_timeout  out  1  one-cycle pulse: no ack within TIMEOUT_CYCLES

Behaviour:
- Reset values: state IDLE; all outputs 0; timeout counter 0; latched address, func3, be and wdata 0. rst asserted mid-transaction drops bus_req asynchronously. No transaction resumes after reset.
- FSM states: IDLE, REQ, DONE.
- acc = mem_read_in | mem_write_in. If both requests are asserted, the access is a write.
- Legal access: func3 is 000/001/010, or 100/101 for reads only. Halfword accesses need addr[0]=0. Word accesses need addr[1:0]=00.
- IDLE, acc legal: latch addr, func3, we, be and shifted wdata. Go to REQ. stall=1 combinationally in this cycle.
- IDLE, acc illegal: misaligned_exc=1 for one cycle. No bus activity. stall=0. Stay in IDLE.
- REQ: bus_req=1 and all bus_* outputs are driven from the latched values. stall=1. The counter increments each cycle.
  - On bus_ack: for a read, capture bus_rdata and register the extended result into load_data. Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: bus_timeout=1 for one cycle. Drop bus_req. Clear the counter. Go to IDLE. load_data is unchanged and stall=0 in that cycle.
- DONE: stall=0, so the pipeline advances at this edge. EX/MEM inputs, still holding the finished access, are ignored. Go to IDLE. This prevents the same access being reissued.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = {4{wdata_in[7:0]}}.
  - SH: be = 0011 << addr[1:0]; wdata = {2{wdata_in[15:0]}}.
  - SW: be = 1111; wdata = wdata_in.
- Load extraction: select the byte/half by addr[1:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW. For reads bus_be is computed the same way as for stores.
- load_data holds its value until the next completed read.
- bus_ack outside REQ is ignored.
- An ack arriving in the same cycle the counter hits TIMEOUT_CYCLES counts as success; no timeout pulse.
- Zero-wait memory (ack in the first REQ cycle): IDLE→REQ→DONE, 2 stall cycles per access.

Decomposition:
- Shared package (riscv_pkg): func3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the lsu_state_t enum {IDLE, REQ, DONE}.
- One natural sub-module: lsu_align, purely combinational.
  - Store side: func3 + addr[1:0] + wdata in, be + shifted wdata + misaligned out.
  - Load side: rdata + func3 + addr[1:0] in, extended result out.
- The FSM and timeout counter stay in the top module.

Test Plan:
- LW at 0x100, ack on the first REQ cycle, rdata=0xDEADBEEF → bus_addr=0x100, be=1111, stall high 2 cycles, load_data=0xDEADBEEF.
- LB at 0x103, rdata=0x80FF0000 → be=1000, load_data=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, wdata_in=0x0000ABCD → bus_we=1, be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
- LW at 0x101 and SH at 0x203 → misalign_exc pulses 1 cycle each, bus_req never asserts, stall=0.
- Load with ack withheld, TIMEOUT_CYCLES=4 → bus_req high 4 cycles, then bus_timeout pulse, state IDLE, load_data unchanged.
- rst asserted during REQ with ack pending → bus_req and stall drop immediately. After release, no bus_req until a new access is presented.
